seq_sort_ctrl: RTL and testbench



---
 rtl/seq_sort_ctrl_pkg.sv | 19 +
 rtl/seq_sort_ctrl_lt_cmp.sv | 12 +
 rtl/seq_sort_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_seq_sort_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_sort_ctrl_pkg.sv
// Shared sorter definitions: state encoding, default sizes, swap counter width.
package seq_sort_ctrl_pkg;

  localparam int WIDTH_DEF  = 10;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 3;
  localparam int SWAP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    return (v == {SWAP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_sort_ctrl_lt_cmp.sv
// Unsigned less-than: out = (a < b). Purely combinational; no flow control.
module lt_cmp #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out
);

  assign out = (a < b);

endmodule

// File: rtl/seq_sort_ctrl.sv
// Bubble sorter over one shared comparator; count-1+1 .. count*(count-1)+1 cycles last-in to first-out.
// in_ready only in LOAD; out_data/out_last hold while out_valid & !out_ready.
module seq_sort_ctrl
  import seq_sort_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];
  logic [CNT_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    full_q, full_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    swapped_q, swapped_d;
  logic [CNT_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [SWAP_CNT_W-1:0]   swap_cnt_q, swap_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    busy_q, busy_d;

  logic [CNT_W-1:0]        idx_nxt;
  logic [CNT_W-1:0]        rd_nxt;
  logic [CNT_W-1:0]        cnt_m1;
  logic [CNT_W-1:0]        cnt_m2;
  logic                    single;
  logic                    lt;
  logic                    any_swap;

  // A full burst stores count as 0; modular subtraction still yields the right last index.
  assign idx_nxt = idx_q + 1'b1;
  assign rd_nxt  = rd_ptr_q + 1'b1;
  assign cnt_m1  = count_q - 1'b1;
  assign cnt_m2  = count_q - 2'd2;
  assign single  = !full_q && (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

  lt_cmp #(.WIDTH(WIDTH)) u_lt (
    .a   (mem_q[idx_nxt]),
    .b   (mem_q[idx_q]),
    .out (lt)
  );

  assign any_swap = swapped_q | lt;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    idx_d       = idx_q;
    swapped_d   = swapped_q;
    rd_ptr_d    = rd_ptr_q;
    swap_cnt_d  = swap_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          if (in_last || (wr_ptr_q == CNT_W'(DEPTH - 1))) begin
            state_d    = ST_SORT;
            count_d    = wr_ptr_q + 1'b1;
            full_d     = (wr_ptr_q == CNT_W'(DEPTH - 1));
            idx_d      = '0;
            swapped_d  = 1'b0;
            swap_cnt_d = '0;
          end
        end
      end

      ST_SORT: begin
        if (single) begin
          state_d  = ST_DRAIN;
          rd_ptr_d = '0;
        end else begin
          if (lt) begin
            mem_d[idx_q]   = mem_q[idx_nxt];
            mem_d[idx_nxt] = mem_q[idx_q];
            swap_cnt_d     = sat_inc(swap_cnt_q);
          end
          if (idx_q == cnt_m2) begin
            idx_d     = '0;
            swapped_d = 1'b0;
            if (!any_swap) begin
              state_d  = ST_DRAIN;
              rd_ptr_d = '0;
            end
          end else begin
            idx_d     = idx_nxt;
            swapped_d = any_swap;
          end
        end
      end

      ST_DRAIN: begin
        // First DRAIN cycle only primes the output register.
        if (!out_valid_q) begin
          out_data_d  = mem_q[rd_ptr_q];
          out_last_d  = (rd_ptr_q == cnt_m1);
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
          end else begin
            rd_ptr_d   = rd_nxt;
            out_data_d = mem_q[rd_nxt];
            out_last_d = (rd_nxt == cnt_m1);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      idx_q       <= '0;
      swapped_q   <= 1'b0;
      rd_ptr_q    <= '0;
      swap_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      idx_q       <= idx_d;
      swapped_q   <= swapped_d;
      rd_ptr_q    <= rd_ptr_d;
      swap_cnt_q  <= swap_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  // Operand storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_seq_sort_ctrl.sv
// Table-driven bench for seq_sort_ctrl with a scoreboard queue of expected sorted beats.
module tb_seq_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [15:0] swap_cnt;

  seq_sort_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int               n;
    logic [0:7][9:0]  din;
    logic [0:7][9:0]  dout;
    int               swaps;
    int               lat;
    logic             stall;
    logic             no_last;
  } vec_t;

  vec_t       tbl [6];
  logic [9:0] sb_q [$];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(input int n, input logic [0:7][9:0] di, input logic [0:7][9:0] dq,
                              input int sw, input int lat, input logic st, input logic nl);
    vec_t v;
    v.n = n; v.din = di; v.dout = dq; v.swaps = sw; v.lat = lat; v.stall = st; v.no_last = nl;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, " in_ready"},  {31'd0, in_ready},  1);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, " out_last"},  {31'd0, out_last},  0);
    chk({tag, " busy"},      {31'd0, busy},      0);
    chk({tag, " out_data"},  {22'd0, out_data},  0);
    chk({tag, " swap_cnt"},  {16'd0, swap_cnt},  0);
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int  cyc;
    int  got;
    int  guard;
    int  k;
    bit  done;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < v.n; i++) sb_q.push_back(v.dout[i]);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v.din[i];
      in_last  = !v.no_last && (i == v.n - 1);
      if (i == 0) chk({tag, " in_ready_load"}, {31'd0, in_ready}, 1);
      @(posedge clk);
    end
    #1;
    chk({tag, " in_ready_drop"}, {31'd0, in_ready}, 0);
    chk({tag, " busy_sort"}, {31'd0, busy}, 1);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'h3FF;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) done = 1'b1;
    end
    if (!done) begin
      chk({tag, " first_valid_timeout"}, 0, 1);
      in_valid = 1'b0;
      sb_q.delete();
      return;
    end
    if (v.lat >= 0) chk({tag, " latency"}, cyc, v.lat);
    got = 0;
    guard = 0;
    k = 0;
    while (got < v.n && guard < 300) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = v.stall ? pat[3 - (k % 4)] : 1'b1;
      k++;
      guard++;
      chk({tag, " out_valid"}, {31'd0, out_valid}, 1);
      chk({tag, " out_data"},  {22'd0, out_data}, {22'd0, sb_q[0]});
      chk({tag, " out_last"},  {31'd0, out_last}, {31'd0, sb_q.size() == 1});
      if (out_ready) begin
        void'(sb_q.pop_front());
        got++;
      end
      @(posedge clk);
    end
    if (got < v.n) begin
      chk({tag, " drain_timeout"}, got, v.n);
      sb_q.delete();
    end
    #1;
    chk({tag, " valid_after"}, {31'd0, out_valid}, 0);
    chk({tag, " in_ready_after"}, {31'd0, in_ready}, 1);
    chk({tag, " busy_after"}, {31'd0, busy}, 0);
    chk({tag, " swap_cnt"}, {16'd0, swap_cnt}, v.swaps);
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t v31;
    tbl[0] = mk(8, {10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0},
                   {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7}, 28, 57, 1'b0, 1'b0);
    tbl[1] = mk(3, {10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0},
                   {10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 0, 3, 1'b0, 1'b0);
    // Four inversions (5>0 twice, 1023>0, 1023>5); equal 5s never swap.
    tbl[2] = mk(5, {10'd5, 10'd5, 10'd1023, 10'd0, 10'd5, 10'd0, 10'd0, 10'd0},
                   {10'd0, 10'd5, 10'd5, 10'd5, 10'd1023, 10'd0, 10'd0, 10'd0}, 4, 17, 1'b0, 1'b0);
    tbl[3] = mk(1, {10'd512, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0},
                   {10'd512, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 0, 2, 1'b0, 1'b0);
    tbl[4] = mk(4, {10'd4, 10'd3, 10'd2, 10'd1, 10'd0, 10'd0, 10'd0, 10'd0},
                   {10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd0, 10'd0, 10'd0}, 6, 13, 1'b1, 1'b0);
    // Full burst terminated by the eighth beat with in_last low.
    tbl[5] = mk(8, {10'd3, 10'd9, 10'd1, 10'd8, 10'd2, 10'd7, 10'd0, 10'd6},
                   {10'd0, 10'd1, 10'd2, 10'd3, 10'd6, 10'd7, 10'd8, 10'd9}, 17, 50, 1'b0, 1'b1);
    v31 = mk(2, {10'd3, 10'd1, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0},
                {10'd1, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 1, 3, 1'b0, 1'b0);

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) run_burst(tbl[t], $sformatf("vec%0d", t));

    // Abort a reverse-order sort partway through.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'(7 - i);
      in_last  = (i == 7);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst busy", {31'd0, busy}, 1);
    chk("pre_rst swaps_nonzero", {31'd0, swap_cnt != 16'd0}, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_sort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(v31, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
